sync_fire_scheduler: RTL and testbench

- Parametrised N-signal state-holding core for synchronous models of asynchronous circuits: one state flop per signal, next-state values (precap) supplied by external gate/latch logic.
- Decides each clock which excited signals fire, under a selectable firing discipline (single, fair round-robin, concurrent).
- Adds on-line monitors the single-fire scheme lacks: sticky per-signal hazard (disabled excitation) flags, deadlock detection and a transition counter.

---
 rtl/sync_sched_pkg.sv | 26 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/sync_fire_scheduler.sv | 114 +++++++++++
 tb/tb_sync_fire_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_sched_pkg.sv
// Shared definitions for the synchronous fire scheduler.
//   mode_e    : firing discipline selected each clock via the 'mode' port
//   IDLE_W    : width of the saturating quiescence counter
//   popcount  : number of set bits in a (zero-extended) fire vector
package sync_sched_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_RR     = 2'd1,
    MODE_MULTI  = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  localparam int IDLE_W = 8;
  localparam int MAX_N  = 64;

  function automatic logic [6:0] popcount(input logic [MAX_N-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: grants the lowest-index requester at or above 'ptr',
// wrapping around to bit 0. Purely combinational.
//   req   : request vector
//   ptr   : starting index of the search (expected < N)
//   grant : one-hot grant (zero when nothing requests)
//   index : binary index of the granted bit
//   valid : at least one request present
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);

  int            idx;
  logic [IW-1:0] idx_w;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch to hold it.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      idx_w = IW'(idx);
      if (!valid && req[idx_w]) begin
        valid = 1'b1;
        grant = N'(1) << idx_w;
        index = idx_w;
      end
    end
  end

endmodule

// File: rtl/sync_fire_scheduler.sv
// State-holding core for synchronous models of asynchronous circuits.
// One flop per modelled signal; external gate logic supplies the next-state
// value (precap). Each clock a fire vector is chosen from the excited bits
// and applied, with hazard, deadlock and transition-count monitors.
//   clk, reset : clock and synchronous active-high reset
//   precap     : next-state value per signal
//   mode       : 0=SINGLE, 1=RR, 2=MULTI, 3=HOLD
//   fire_sel   : chosen index in SINGLE mode
//   fire_mask  : concurrent fire set in MULTI mode
//   state      : current signal values
//   excited    : state ^ precap
//   fired      : fire vector applied at the last edge
//   hazard     : sticky flags, excitation withdrawn without firing
//   hazard_any : OR of hazard
//   deadlock   : no excitation for DL_LIMIT consecutive cycles
//   txn_count  : total single-bit transitions since reset (wraps)
module sync_fire_scheduler
  import sync_sched_pkg::*;
#(
  parameter int           N        = 8,
  parameter logic [N-1:0] INIT     = '0,
  parameter logic [N-1:0] ENV_MASK = '0,
  parameter int           DL_LIMIT = 16,
  parameter int           CNT_W    = 16,
  parameter int           IW       = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     precap,
  input  logic [1:0]       mode,
  input  logic [IW-1:0]    fire_sel,
  input  logic [N-1:0]     fire_mask,
  output logic [N-1:0]     state,
  output logic [N-1:0]     excited,
  output logic [N-1:0]     fired,
  output logic [N-1:0]     hazard,
  output logic             hazard_any,
  output logic             deadlock,
  output logic [CNT_W-1:0] txn_count
);

  logic [IW-1:0]     rr_ptr;
  logic [N-1:0]      prev_exc;
  logic [IDLE_W-1:0] idle_cnt;

  logic [N-1:0]  fire;
  logic [N-1:0]  sel_onehot;
  logic [N-1:0]  rr_grant;
  logic [IW-1:0] rr_index;
  logic          rr_valid;
  logic [N-1:0]  hz_set;
  mode_e         cur_mode;

  assign excited    = state ^ precap;
  assign cur_mode   = mode_e'(mode);
  assign sel_onehot = N'(1) << fire_sel;
  assign hazard_any = |hazard;
  assign deadlock   = int'(idle_cnt) >= DL_LIMIT;

  // Excitation that was present last cycle, was not fired, and is gone now.
  assign hz_set = prev_exc & ~fired & ~excited & ~ENV_MASK;

  rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .req   (excited),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .index (rr_index),
    .valid (rr_valid)
  );

  always_comb begin
    fire = '0;
    unique case (cur_mode)
      // An out-of-range or non-excited selection stutters.
      MODE_SINGLE: if (int'(fire_sel) < N) fire = excited & sel_onehot;
      MODE_RR:     fire = rr_grant;
      MODE_MULTI:  fire = fire_mask & excited;
      MODE_HOLD:   fire = '0;
      default:     fire = '0;
    endcase
  end

  // NOTE: all state registers use non-blocking assignment so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      fired     <= '0;
      hazard    <= '0;
      rr_ptr    <= '0;
      idle_cnt  <= '0;
      prev_exc  <= '0;
      txn_count <= '0;
    end else begin
      state     <= state ^ fire;
      fired     <= fire;
      hazard    <= hazard | hz_set;
      prev_exc  <= excited;
      txn_count <= txn_count + CNT_W'(popcount(MAX_N'(fire)));

      if (excited == '0) begin
        if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end

      // Pointer only moves on an actual round-robin fire; kept across modes.
      if (cur_mode == MODE_RR && rr_valid) begin
        rr_ptr <= (int'(rr_index) == N - 1) ? '0 : rr_index + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fire_scheduler.sv
// Self-checking bench for sync_fire_scheduler (N=4, INIT=0101, ENV bit 3,
// DL_LIMIT=3). A behavioural model tracks the expected outputs; one process
// compares every cycle, and directed steps pin literal values.
module tb_sync_fire_scheduler;

  localparam int           N        = 4;
  localparam logic [3:0]   INIT     = 4'b0101;
  localparam logic [3:0]   ENV_MASK = 4'b1000;
  localparam int           DL_LIMIT = 3;
  localparam int           CNT_W    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        precap;
  logic [1:0]        mode;
  logic [1:0]        fire_sel;
  logic [3:0]        fire_mask;
  logic [3:0]        state, excited, fired, hazard;
  logic              hazard_any, deadlock;
  logic [CNT_W-1:0]  txn_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit m_valid = 1'b0;
  bit done    = 1'b0;

  // Model state
  logic [3:0]       m_state, m_fired, m_haz, m_prev;
  int               m_ptr, m_idle;
  logic [CNT_W-1:0] m_cnt;

  always #5 clk = ~clk;

  sync_fire_scheduler #(
    .N(N), .INIT(INIT), .ENV_MASK(ENV_MASK), .DL_LIMIT(DL_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .precap(precap), .mode(mode),
    .fire_sel(fire_sel), .fire_mask(fire_mask), .state(state),
    .excited(excited), .fired(fired), .hazard(hazard),
    .hazard_any(hazard_any), .deadlock(deadlock), .txn_count(txn_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Fire vector implied by the firing rules for a given mode and excitation.
  function automatic logic [3:0] model_fire(input int md, input int sel,
                                            input logic [3:0] msk,
                                            input logic [3:0] exc, input int ptr);
    logic [3:0] f, oh;
    f = 4'b0000;
    case (md)
      0: begin
        oh = 4'b0001 << sel;
        if (sel < N && (exc & oh) != 4'b0000) f = oh;
      end
      1: for (int off = 0; off < N; off++) begin
        oh = 4'b0001 << ((ptr + off) % N);
        if (f == 4'b0000 && (exc & oh) != 4'b0000) f = oh;
      end
      2: f = msk & exc;
      default: f = 4'b0000;
    endcase
    return f;
  endfunction

  // Behavioural model, advanced on every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_state = INIT; m_fired = 4'b0000; m_haz = 4'b0000; m_prev = 4'b0000;
        m_ptr = 0; m_idle = 0; m_cnt = '0;
        m_valid = 1'b1;
      end else if (m_valid) begin
        logic [3:0] exc, f;
        exc = m_state ^ precap;
        f = model_fire(int'(mode), int'(fire_sel), fire_mask, exc, m_ptr);
        m_haz = m_haz | (m_prev & ~m_fired & ~exc & ~ENV_MASK);
        m_prev = exc;
        if (exc == 4'b0000) m_idle = (m_idle < 255) ? m_idle + 1 : 255;
        else m_idle = 0;
        if (mode == 2'd1)
          for (int k = 0; k < N; k++)
            if (f == (4'b0001 << k)) m_ptr = (k + 1) % N;
        m_state = m_state ^ f;
        m_fired = f;
        m_cnt = m_cnt + CNT_W'($countones(f));
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid && !done) begin
        check("state",      64'(state),      64'(m_state));
        check("excited",    64'(excited),    64'(m_state ^ precap));
        check("fired",      64'(fired),      64'(m_fired));
        check("hazard",     64'(hazard),     64'(m_haz));
        check("hazard_any", 64'(hazard_any), 64'(m_haz != 4'b0000));
        check("deadlock",   64'(deadlock),   64'(m_idle >= DL_LIMIT));
        check("txn_count",  64'(txn_count),  64'(m_cnt));
      end
    end
  end

  task automatic set_in(input logic r, input logic [3:0] pc, input logic [1:0] md,
                        input logic [1:0] sel, input logic [3:0] msk);
    reset = r; precap = pc; mode = md; fire_sel = sel; fire_mask = msk;
  endtask

  // Advance one edge; return 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(1'b1, 4'b1111, 2'd3, 2'd0, 4'b0000);
    tick(); tick();
    check("rst_state",   64'(state),     64'h5);
    check("rst_excited", 64'(excited),   64'hA);
    check("rst_fired",   64'(fired),     64'h0);
    check("rst_txn",     64'(txn_count), 64'h0);

    // SINGLE
    set_in(1'b0, 4'b1111, 2'd0, 2'd1, 4'b0000); tick();
    check("single_state", 64'(state),     64'h7);
    check("single_fired", 64'(fired),     64'h2);
    check("single_txn",   64'(txn_count), 64'h1);
    set_in(1'b0, 4'b1111, 2'd0, 2'd0, 4'b0000); tick();
    check("stutter_state", 64'(state), 64'h7);
    check("stutter_fired", 64'(fired), 64'h0);

    // Clear to 0000 via MULTI, then RR sweep
    set_in(1'b0, 4'b0000, 2'd2, 2'd0, 4'b1111); tick();
    check("clr_state", 64'(state), 64'h0);
    set_in(1'b0, 4'b1111, 2'd1, 2'd0, 4'b0000);
    tick(); check("rr_fire0", 64'(fired), 64'h1);
    tick(); check("rr_fire1", 64'(fired), 64'h2);
    tick(); check("rr_fire2", 64'(fired), 64'h4);
    tick(); check("rr_fire3", 64'(fired), 64'h8);
    check("rr_txn", 64'(txn_count), 64'd8);
    set_in(1'b0, 4'b0000, 2'd1, 2'd0, 4'b0000); tick();
    check("rr_wrap", 64'(fired), 64'h1);

    // MULTI partial
    set_in(1'b0, 4'b0000, 2'd2, 2'd0, 4'b1111); tick();
    set_in(1'b0, 4'b1011, 2'd2, 2'd0, 4'b1110); tick();
    check("multi_state", 64'(state),     64'hA);
    check("multi_fired", 64'(fired),     64'hA);
    check("multi_txn",   64'(txn_count), 64'd14);
    check("multi_exc",   64'(excited),   64'h1);

    // Fire the leftover bit0, then withdraw an excitation on bit2
    set_in(1'b0, 4'b1011, 2'd0, 2'd0, 4'b0000); tick();
    set_in(1'b0, 4'b1111, 2'd3, 2'd0, 4'b0000); tick();
    set_in(1'b0, 4'b1011, 2'd3, 2'd0, 4'b0000); tick();
    check("hazard_set", 64'(hazard),     64'h4);
    check("hazard_any", 64'(hazard_any), 64'h1);

    // Same on environment bit 3: no flag
    set_in(1'b0, 4'b0011, 2'd3, 2'd0, 4'b0000); tick();
    set_in(1'b0, 4'b1011, 2'd3, 2'd0, 4'b0000); tick();
    check("hazard_env", 64'(hazard), 64'h4);

    // Deadlock after DL_LIMIT quiescent cycles
    set_in(1'b0, 4'b0011, 2'd3, 2'd0, 4'b0000); tick();
    set_in(1'b0, 4'b1011, 2'd3, 2'd0, 4'b0000);
    tick(); check("dl_1", 64'(deadlock), 64'h0);
    tick(); check("dl_2", 64'(deadlock), 64'h0);
    tick(); check("dl_3", 64'(deadlock), 64'h1);
    set_in(1'b0, 4'b1010, 2'd3, 2'd0, 4'b0000); tick();
    check("dl_clear", 64'(deadlock), 64'h0);
    set_in(1'b0, 4'b1010, 2'd0, 2'd0, 4'b0000); tick();
    check("fire_b0_txn", 64'(txn_count), 64'd16);
    check("hazard_keep", 64'(hazard),    64'h4);

    // Mid-operation reset
    set_in(1'b1, 4'b0000, 2'd2, 2'd0, 4'b1111); tick();
    check("rst2_state",  64'(state),     64'h5);
    check("rst2_hazard", 64'(hazard),    64'h0);
    check("rst2_txn",    64'(txn_count), 64'h0);

    // Randomised phase, checked by the per-cycle comparison
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] pc;
      case ($urandom_range(0, 3))
        0: pc = 4'($urandom);
        1: pc = m_state;
        default: pc = m_state ^ (4'($urandom) & 4'($urandom));
      endcase
      set_in($urandom_range(0, 63) == 0, pc, 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 4'($urandom));
      tick();
    end

    done = 1'b1;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
